pack_framer: RTL
================

Name: pack_framer

Overview:
- Sits directly downstream of the preamble correlator in the DeFEC receive chain. Consumes its 5-bit soft-symbol stream plus the start-of-packet flag.
- After a detection, discards an optional guard run of symbols, then emits exactly one fixed-length payload frame to the FEC decoder, marked with sop and eop.
- Suppresses retriggers from correlation sidelobes and counts frames and dropped detections.

Parameters:
- cFRAME_LEN, 512: payload soft symbols per frame (≥1).
- cSKIP, 0: valid symbols discarded after the detection sample before the payload starts (≥0).
- cGAP, 16: valid symbols after eop during which isop is ignored (≥0).
- cCNT_W, 16: width of the frame counter.
- cDROP_W, 8: width of the dropped-detection counter.

Ports:
- iclk  in  1  system clock
- irst  in  1  reset, asynchronous, active-low
- idat  in  5  soft symbol from correlator, aligned with isop
- ival  in  1  idat/isop valid
- isop  in  1  preamble detected; the qualifying sample is the last preamble symbol
- odat  out  5  payload soft symbol
- oval  out  1  odat valid
- osop  out  1  first payload symbol
- oeop  out  1  last payload symbol
- obusy  out  1  high in SKIP/DATA/GAP
- oframe_cnt  out  cCNT_W  completed frames, wraps modulo 2^cCNT_W
- odrop_cnt  out  cDROP_W  isop events ignored while busy, saturating

Behaviour:
- Reset (irst=0, asynchronous):
  - State goes to IDLE.
  - All outputs and counters go to 0 immediately.
  - A frame in progress is abandoned and no eop is issued.
- All counting is qualified by ival; cycles with ival=0 freeze state and counters and force oval/osop/oeop to 0.
- isop is ignored when ival=0.
- Outputs are registered. Latency is 1 clock from the input valid sample to oval. odat holds its last value when oval=0.
- States:
  - IDLE: on ival&isop, go to SKIP if cSKIP>0, else DATA. The detection sample itself is never output.
  - SKIP: count cSKIP valid samples, discard them, then go to DATA.
  - DATA: output each valid sample. osop is asserted on the 1st, oeop on the cFRAME_LEN-th. After the last one, oframe_cnt increments and the block goes to GAP if cGAP>0, else IDLE.
  - GAP: discard cGAP valid samples, then go to IDLE.
- With cFRAME_LEN=1, osop and oeop are asserted in the same cycle.
- A valid isop in SKIP, DATA or GAP:
  - is ignored and odrop_cnt increments, holding at all-ones;
  - has no effect on the frame.
- isop on the sample that completes GAP (last gap sample) is also dropped. The first sample after entering IDLE may start a new frame.
- With cGAP=0, an isop coincident with the eop sample is dropped.
- Sustained isop (multiple consecutive samples above threshold) triggers only on the first sample.
- Symbol-counter width is $clog2(max(cFRAME_LEN,cSKIP,cGAP)+1). The counter restarts at 0 on every state entry.
- obusy is registered and asserts in the cycle after the triggering sample.

Decomposition:
- Shared package defec_pkg holds:
  - the state enum (IDLE, SKIP, DATA, GAP);
  - cSOFT_W=5;
  - the default cFRAME_LEN.
- No sub-module is needed; the single FSM plus counters fits one module.

Test Plan:
- Default params, isop on sample 100 of a continuous ramp (idat=n mod 32):
  - 512 oval pulses with odat starting at 101 mod 32=5;
  - osop on the first, oeop on the 512th;
  - oframe_cnt=1, odrop_cnt=0.
- cSKIP=3, cFRAME_LEN=4, ramp data, isop at sample 10: odat = 14,15,16,17, with osop at 14 and oeop at 17.
- Random ival duty 50%, cFRAME_LEN=8: exactly 8 oval; no oval/osop/oeop while ival=0; payload is the next 8 valid samples after detection.
- isop held high for 5 consecutive samples, then isop at DATA symbol 20 and at GAP symbol 3: one frame, odrop_cnt=6 (4 sustained + 2).
- Frames back-to-back with cGAP=0, isop on the sample right after eop: second frame starts with no idle gap; oframe_cnt=2.
- irst pulsed low at DATA symbol 200: all outputs are 0 asynchronously, no oeop follows. The next isop yields a complete 512-symbol frame and oframe_cnt=1.

Source files
------------

// File: rtl/defec_pkg.sv
// Shared types and constants for the DeFEC receive chain.
// Holds the framer state encoding, soft-symbol width and default frame length.
package defec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SKIP = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_e;

    localparam int cSOFT_W        = 5;
    localparam int cFRAME_LEN_DEF = 512;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pack_framer.sv
// Packet framer: after a preamble detection, skips a guard run and emits one
// fixed-length payload frame with sop/eop, then ignores retriggers for a gap.
module pack_framer
    import defec_pkg::*;
#(
    parameter int cFRAME_LEN = cFRAME_LEN_DEF,
    parameter int cSKIP      = 0,
    parameter int cGAP       = 16,
    parameter int cCNT_W     = 16,
    parameter int cDROP_W    = 8
) (
    input  logic               iclk,
    input  logic               irst,
    input  logic [cSOFT_W-1:0] idat,
    input  logic               ival,
    input  logic               isop,
    output logic [cSOFT_W-1:0] odat,
    output logic               oval,
    output logic               osop,
    output logic               oeop,
    output logic               obusy,
    output logic [cCNT_W-1:0]  oframe_cnt,
    output logic [cDROP_W-1:0] odrop_cnt
);

    localparam int cSYM_W = $clog2(max3(cFRAME_LEN, cSKIP, cGAP) + 1);

    // Terminal counts; SKIP/GAP are never entered when their length is 0.
    localparam logic [cSYM_W-1:0] cLAST_SKIP = cSYM_W'((cSKIP > 0) ? cSKIP - 1 : 0);
    localparam logic [cSYM_W-1:0] cLAST_DATA = cSYM_W'(cFRAME_LEN - 1);
    localparam logic [cSYM_W-1:0] cLAST_GAP  = cSYM_W'((cGAP > 0) ? cGAP - 1 : 0);

    state_e               state_q, state_d;
    logic [cSYM_W-1:0]    sym_q, sym_d;
    logic [cSOFT_W-1:0]   odat_q, odat_d;
    logic                 oval_q, oval_d;
    logic                 osop_q, osop_d;
    logic                 oeop_q, oeop_d;
    logic                 busy_q, busy_d;
    logic [cCNT_W-1:0]    frame_q, frame_d;
    logic [cDROP_W-1:0]   drop_q, drop_d;
    logic                 drop_hit;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        sym_d    = sym_q;
        odat_d   = odat_q;
        oval_d   = 1'b0;
        osop_d   = 1'b0;
        oeop_d   = 1'b0;
        frame_d  = frame_q;
        drop_d   = drop_q;
        drop_hit = 1'b0;

        if (ival) begin
            unique case (state_q)
                IDLE: begin
                    if (isop) begin
                        sym_d   = '0;
                        state_d = (cSKIP > 0) ? SKIP : DATA;
                    end
                end
                SKIP: begin
                    drop_hit = isop;
                    if (sym_q == cLAST_SKIP) begin
                        sym_d   = '0;
                        state_d = DATA;
                    end else begin
                        sym_d = sym_q + cSYM_W'(1);
                    end
                end
                DATA: begin
                    drop_hit = isop;
                    oval_d   = 1'b1;
                    odat_d   = idat;
                    osop_d   = (sym_q == '0);
                    oeop_d   = (sym_q == cLAST_DATA);
                    if (sym_q == cLAST_DATA) begin
                        sym_d   = '0;
                        frame_d = frame_q + cCNT_W'(1);
                        state_d = (cGAP > 0) ? GAP : IDLE;
                    end else begin
                        sym_d = sym_q + cSYM_W'(1);
                    end
                end
                GAP: begin
                    drop_hit = isop;
                    if (sym_q == cLAST_GAP) begin
                        sym_d   = '0;
                        state_d = IDLE;
                    end else begin
                        sym_d = sym_q + cSYM_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase

            if (drop_hit && (drop_q != '1)) begin
                drop_d = drop_q + cDROP_W'(1);
            end
        end

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            state_q <= IDLE;
            sym_q   <= '0;
            odat_q  <= '0;
            oval_q  <= 1'b0;
            osop_q  <= 1'b0;
            oeop_q  <= 1'b0;
            busy_q  <= 1'b0;
            frame_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            sym_q   <= sym_d;
            odat_q  <= odat_d;
            oval_q  <= oval_d;
            osop_q  <= osop_d;
            oeop_q  <= oeop_d;
            busy_q  <= busy_d;
            frame_q <= frame_d;
            drop_q  <= drop_d;
        end
    end

    assign odat       = odat_q;
    assign oval       = oval_q;
    assign osop       = osop_q;
    assign oeop       = oeop_q;
    assign obusy      = busy_q;
    assign oframe_cnt = frame_q;
    assign odrop_cnt  = drop_q;

endmodule
